scan_encoder: RTL

SCAN_ENCODER -- requirements
Module: scan_encoder

---
 rtl/scan_encoder.sv | 97 +++++++++
 1 files changed

// File: rtl/scan_encoder.sv
// Serialises a captured multi-hot vector into one index beat per set bit,
// lowest-first or highest-first, with a single flagged beat for an all-zero vector.
module scan_encoder #(
  parameter int N_IN      = 8,
  parameter int MSB_FIRST = 0,
  localparam int IDX_W    = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t            state_reg, state_next;
  logic [N_IN-1:0]   pend_reg, pend_next;
  logic              zero_reg, zero_next;
  logic              live_reg;
  logic [IDX_W-1:0]  enc_idx;
  logic [N_IN-1:0]   clr_mask;
  logic              last_flag;

  // live_reg keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      zero_reg  <= 1'b0;
      live_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      zero_reg  <= zero_next;
      live_reg  <= 1'b1;
    end
  end

  // Later loop iterations win, so scan direction picks the priority end
  always_comb begin
    enc_idx = '0;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < N_IN; i++)
        if (pend_reg[i]) enc_idx = IDX_W'(i);
    end else begin
      for (int i = N_IN - 1; i >= 0; i--)
        if (pend_reg[i]) enc_idx = IDX_W'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_clr
      assign clr_mask[gi] = (enc_idx == IDX_W'(gi));
    end
  endgenerate

  assign last_flag = ((pend_reg & (pend_reg - N_IN'(1))) == '0);

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    zero_next  = zero_reg;
    in_ready   = live_reg && (state_reg == IDLE);
    out_valid  = (state_reg == EMIT);
    case (state_reg)
      IDLE: begin
        if (in_valid && in_ready) begin
          pend_next  = in_vec;
          zero_next  = (in_vec == '0);
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pend_next = pend_reg & ~clr_mask;
          if (last_flag) begin
            state_next = IDLE;
            zero_next  = 1'b0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign out_idx  = out_valid ? enc_idx : '0;
  assign out_last = out_valid & last_flag;
  assign out_zero = out_valid & zero_reg;

endmodule
